reset_sequencer: RTL

Synthesizable reset and run-window controller that replaces open-coded bench reset/clock sequencing in the DUT harness. After reset it holds all downstream domain resets asserted for a fixed number of cycles and releases them one domain at a time, in staggered order. It then grants a bounded or unbounded run window through a registered clock-enable. Software can re-run the whole sequence through a req/ack handshake.

---
 rtl/reset_seq_pkg.sv | 23 ++
 rtl/rs_cycle_counter.sv | 26 ++
 rtl/reset_sequencer.sv | 174 +++++++++++++++++
 3 files changed

// File: rtl/reset_seq_pkg.sv
// Shared types, default parameter values and helpers for the reset sequencer.
package reset_seq_pkg;

   typedef enum logic [1:0] {
      ST_ASSERT  = 2'd0,
      ST_RELEASE = 2'd1,
      ST_RUN     = 2'd2,
      ST_DONE    = 2'd3
   } state_t;

   localparam int DEF_NUM_DOMAINS  = 4;
   localparam int DEF_HOLD_CYCLES  = 2;
   localparam int DEF_STAGGER      = 3;
   localparam bit DEF_ACTIVE_RESET = 1'b0;
   localparam int DEF_CNT_W        = 16;
   localparam int DEF_WDOG_CYCLES  = 100;

   // Edge index (counted from ASSERT entry) at which RUN is entered.
   function automatic int run_entry_edge(input int hold, input int stagger, input int domains);
      return hold + (domains - 1) * stagger + 1;
   endfunction

endpackage

// File: rtl/rs_cycle_counter.sv
// Clearable up-counter with an equality compare against a target value.
module rs_cycle_counter
   import reset_seq_pkg::*;
#(
   parameter int W = 8
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         clear,
   input  logic         en,
   input  logic [W-1:0] target,
   output logic [W-1:0] count,
   output logic         hit
);

   always_ff @(posedge clk) begin
      if (reset || clear) begin
         count <= '0;
      end else if (en) begin
         count <= count + W'(1);
      end
   end

   assign hit = (count == target);

endmodule

// File: rtl/reset_sequencer.sv
// Staggered multi-domain reset release followed by a bounded/unbounded run window.
// Optional watchdog compiled in with `define RESET_SEQ_WDOG_EN.
module reset_sequencer
   import reset_seq_pkg::*;
#(
   parameter int NUM_DOMAINS  = DEF_NUM_DOMAINS,
   parameter int HOLD_CYCLES  = DEF_HOLD_CYCLES,
   parameter int STAGGER      = DEF_STAGGER,
   parameter bit ACTIVE_RESET = DEF_ACTIVE_RESET,
   parameter int CNT_W        = DEF_CNT_W,
   parameter int WDOG_CYCLES  = DEF_WDOG_CYCLES
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   sw_reset_req,
   output logic                   sw_reset_ack,
   input  logic                   stop,
   input  logic [CNT_W-1:0]       run_cycles,
   input  logic                   kick,
   output logic [NUM_DOMAINS-1:0] domain_rst,
   output logic                   run_en,
   output logic                   done,
   output logic                   busy,
   output logic                   wdog_fired
);

   localparam int RUN_EDGE = run_entry_edge(HOLD_CYCLES, STAGGER, NUM_DOMAINS);
   localparam int SEQ_W    = $clog2(RUN_EDGE + 1);

   state_t                   state;
   state_t                   state_nxt;
   logic                     enter_assert;
   logic                     enter_run;

   logic [SEQ_W-1:0]         seq_count;
   logic [SEQ_W-1:0]         edge_idx;
   logic                     seq_hit;

   logic [CNT_W-1:0]         run_lim;
   logic [CNT_W-1:0]         run_target;
   logic [CNT_W-1:0]         run_count_unused;
   logic                     run_hit;
   logic                     run_fin;

   logic                     req_q;
   logic                     req_prev;
   logic                     req_rise;
   logic                     pending;

   logic [NUM_DOMAINS-1:0]   released;
   logic [NUM_DOMAINS-1:0]   release_set;

   logic                     wdog_fire;

   assign busy     = (state == ST_ASSERT) || (state == ST_RELEASE);
   assign done     = (state == ST_DONE);
   assign req_rise = req_q & ~req_prev;

   // edge_idx is the number of the upcoming edge relative to ASSERT entry
   assign edge_idx     = seq_count + SEQ_W'(1);
   assign enter_assert = (state_nxt == ST_ASSERT) && (state != ST_ASSERT);
   assign enter_run    = (state_nxt == ST_RUN) && (state != ST_RUN);

   rs_cycle_counter #(.W(SEQ_W)) u_seq_cnt (
      .clk    (clk),
      .reset  (reset),
      .clear  (enter_assert),
      .en     (busy),
      .target (SEQ_W'(RUN_EDGE - 1)),
      .count  (seq_count),
      .hit    (seq_hit)
   );

   assign run_target = run_lim - CNT_W'(1);
   assign run_fin    = run_en && run_hit && (run_lim != '0);

   rs_cycle_counter #(.W(CNT_W)) u_run_cnt (
      .clk    (clk),
      .reset  (reset),
      .clear  (enter_run),
      .en     (run_en),
      .target (run_target),
      .count  (run_count_unused),
      .hit    (run_hit)
   );

`ifdef RESET_SEQ_WDOG_EN
   localparam int WD_W = $clog2(WDOG_CYCLES + 1);

   logic [WD_W-1:0] wd_count_unused;
   logic            wd_hit;
   logic            wd_active;

   assign wd_active = (state == ST_RUN) && !stop;
   assign wdog_fire = wd_active && !kick && wd_hit;

   rs_cycle_counter #(.W(WD_W)) u_wd_cnt (
      .clk    (clk),
      .reset  (reset),
      .clear  (enter_run | kick),
      .en     (wd_active),
      .target (WD_W'(WDOG_CYCLES - 1)),
      .count  (wd_count_unused),
      .hit    (wd_hit)
   );

   always_ff @(posedge clk) begin
      if (reset) begin
         wdog_fired <= 1'b0;
      end else begin
         wdog_fired <= wdog_fire;
      end
   end
`else
   logic cfg_unused;

   assign cfg_unused = kick ^ (WDOG_CYCLES > 0);
   assign wdog_fire  = 1'b0;
   assign wdog_fired = 1'b0;
`endif

   always_comb begin
      state_nxt = state;
      case (state)
         ST_ASSERT: begin
            if (edge_idx == SEQ_W'(HOLD_CYCLES)) state_nxt = ST_RELEASE;
         end
         ST_RELEASE: begin
            if (seq_hit) state_nxt = ST_RUN;
         end
         ST_RUN: begin
            // a restart request outranks the end of the window
            if (req_rise || wdog_fire) state_nxt = ST_ASSERT;
            else if (run_fin)          state_nxt = ST_DONE;
         end
         ST_DONE: begin
            if (req_rise) state_nxt = ST_ASSERT;
         end
         default: state_nxt = ST_ASSERT;
      endcase
   end

   for (genvar k = 0; k < NUM_DOMAINS; k++) begin : g_dom
      assign release_set[k] = busy && (edge_idx == SEQ_W'(HOLD_CYCLES + k * STAGGER));
      assign domain_rst[k]  = released[k] ? ~ACTIVE_RESET : ACTIVE_RESET;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state        <= ST_ASSERT;
         req_q        <= 1'b0;
         req_prev     <= 1'b0;
         pending      <= 1'b0;
         sw_reset_ack <= 1'b0;
         run_en       <= 1'b0;
         released     <= '0;
      end else begin
         state        <= state_nxt;
         req_q        <= sw_reset_req;
         req_prev     <= req_q;
         pending      <= enter_run ? 1'b0 : (pending | req_rise);
         sw_reset_ack <= enter_run & (pending | req_rise);
         run_en       <= (state_nxt == ST_RUN) & ~stop;
         if (state_nxt == ST_ASSERT) released <= '0;
         else                        released <= released | release_set;
      end
   end

   // window length is captured once on RUN entry
   always_ff @(posedge clk) begin
      if (enter_run) run_lim <= run_cycles;
   end

endmodule
